// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and mem-side signal bundle for mem_port_arbiter
// slave  : arbiter view (takes client requests and mem q, drives grants, read-valid and mem controls)
// master : client/mem view (the opposite directions)
interface mem_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr_in;
    logic [NREQ*DW-1:0] wdata_in;
    logic [NREQ-1:0]    wren_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic [2:0]         owner;
    logic               lock_break;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_wren;
    logic [DW-1:0]      mem_q;

    modport slave (
        input  req, lock, addr_in, wdata_in, wren_in, mem_q,
        output gnt, rvalid, rdata, owner, lock_break, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req, lock, addr_in, wdata_in, wren_in, mem_q,
        input  gnt, rvalid, rdata, owner, lock_break, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter with per-client lock for a shared single-port mem
// clk, rst : single clock, synchronous active-high reset
// bus      : mem_port_arbiter_if.slave (client req/lock/addr/wdata/wren in, gnt/rvalid/rdata/owner/lock_break out,
//            mem_addr/mem_wdata/mem_wren out, mem_q in)
// MEM_ARB_WATCHDOG_EN : when defined, a held lock is revoked after MAX_HOLD contended keep cycles
module mem_port_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 256
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_q, last_d;     // last granted client, lowest priority on rotate

    logic            acc;                // granted client is actually requesting this cycle
    logic            keep_raw;           // granted client asks to hold the port
    logic            keep;
    logic            force_rot;
    logic            wren_sel;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic            found;
    logic [3:0]      cand;

    assign acc      = |(gnt_q & bus.req);
    assign keep_raw = |(gnt_q & bus.req & bus.lock);
    assign keep     = keep_raw & ~force_rot;

    // Client 0's values stay on the mem bus whenever there is no live access.
    always_comb begin
        addr_sel  = bus.addr_in[AW-1:0];
        wdata_sel = bus.wdata_in[DW-1:0];
        wren_sel  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i] && bus.req[i]) begin
                addr_sel  = bus.addr_in[i*AW +: AW];
                wdata_sel = bus.wdata_in[i*DW +: DW];
                wren_sel  = bus.wren_in[i];
            end
        end
    end

    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.mem_wren  = acc & wren_sel & ~rst;
    assign bus.rdata     = bus.mem_q;

    // The mem registers its read, so the valid strobe trails the access by one cycle.
    always_comb begin
        rvalid_d = (acc && !wren_sel) ? gnt_q : '0;
    end

    // Cyclic search starting just after the last owner.
    always_comb begin
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        found   = 1'b0;
        cand    = '0;
        if (!keep) begin
            gnt_d   = '0;
            owner_d = '0;
            for (int k = 1; k <= NREQ; k++) begin
                cand = {1'b0, last_q} + 4'(k);
                if (cand >= 4'(NREQ)) begin
                    cand = cand - 4'(NREQ);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && cand == 4'(i) && bus.req[i]) begin
                        found    = 1'b1;
                        gnt_d[i] = 1'b1;
                        owner_d  = 3'(i);
                        last_d   = 3'(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            owner_q  <= '0;
            last_q   <= 3'(NREQ - 1);
        end else begin
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.owner  = owner_q;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          lock_break_q, lock_break_d;
    logic          others;

    // Only contended holds count; an uncontested lock never trips the watchdog.
    always_comb begin
        others       = |(bus.req & ~gnt_q);
        force_rot    = keep_raw && others && (hold_q == HW'(MAX_HOLD));
        hold_d       = (keep_raw && others && !force_rot) ? hold_q + 1'b1 : '0;
        lock_break_d = force_rot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            lock_break_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            lock_break_q <= lock_break_d;
        end
    end

    assign bus.lock_break = lock_break_q;
`else
    assign force_rot = 1'b0;
    // MAX_HOLD has no role without the watchdog; the term below is constant 0.
    assign bus.lock_break = 1'b0 & (MAX_HOLD == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a 256x8 registered-read mem model
module tb_mem_port_arbiter;
    localparam int K_GNT   = 0;
    localparam int K_OWN   = 1;
    localparam int K_RV    = 2;
    localparam int K_WREN  = 3;
    localparam int K_MADDR = 4;
    localparam int K_MWD   = 5;
    localparam int K_LB    = 6;

    typedef struct { int t; int kind; logic [31:0] val; } exp_t;
    typedef struct { int t; logic [2:0] rv; logic [7:0] data; } rd_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    logic [7:0] mem [256];

    mem_port_arbiter_if #(.NREQ(3), .AW(8), .DW(8)) bus ();

    mem_port_arbiter #(.NREQ(3), .AW(8), .DW(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            bus.mem_q <= 8'h00;
        end else begin
            if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_q <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic string kind_name(input int kind);
        case (kind)
            K_GNT:   return "gnt";
            K_OWN:   return "owner";
            K_RV:    return "rvalid";
            K_WREN:  return "mem_wren";
            K_MADDR: return "mem_addr";
            K_MWD:   return "mem_wdata";
            default: return "lock_break";
        endcase
    endfunction

    function automatic logic [31:0] sample(input int kind);
        case (kind)
            K_GNT:   return 32'(bus.gnt);
            K_OWN:   return 32'(bus.owner);
            K_RV:    return 32'(bus.rvalid);
            K_WREN:  return 32'(bus.mem_wren);
            K_MADDR: return 32'(bus.mem_addr);
            K_MWD:   return 32'(bus.mem_wdata);
            default: return 32'(bus.lock_break);
        endcase
    endfunction

    task automatic exp_at(input int dc, input int kind, input logic [31:0] val);
        exp_t e;
        e.t = cyc + dc; e.kind = kind; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input int dc, input int client, input logic [7:0] data);
        rd_t r;
        r.t = cyc + dc; r.rv = 3'b001 << client; r.data = data;
        rd_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scores every due expectation and every read response the DUT presents.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].t == cyc) begin
                check(kind_name(exp_q[i].kind), sample(exp_q[i].kind), exp_q[i].val);
                exp_q.delete(i);
            end else if (exp_q[i].t < cyc) begin
                check({"stale_", kind_name(exp_q[i].kind)}, 32'(exp_q[i].t), 32'(cyc));
                exp_q.delete(i);
            end
        end
        if (bus.rvalid != 3'b000) begin
            if (rd_q.size() == 0) begin
                check("unexpected_rvalid", 32'(bus.rvalid), 32'h0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check("rvalid_cycle", 32'(cyc), 32'(r.t));
                check("rvalid_vec", 32'(bus.rvalid), 32'(r.rv));
                check("rdata", 32'(bus.rdata), 32'(r.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b1;
        bus.req = 3'b111; bus.lock = 3'b000; bus.wren_in = 3'b000;
        bus.addr_in = '0; bus.wdata_in = '0;

        step();                                           // cycle 1, in reset
        clr = 1'b0;
        exp_at(0, K_GNT, 0); exp_at(0, K_RV, 0); exp_at(0, K_WREN, 0); exp_at(0, K_OWN, 0);
        step();                                           // cycle 2, still in reset
        exp_at(0, K_GNT, 0); exp_at(0, K_RV, 0);
        rst = 1'b0;

        // Round-robin with all three requesting, every grant is a read of addr 0.
        exp_at(1, K_GNT, 3'b001); exp_at(1, K_OWN, 0);
        exp_at(2, K_GNT, 3'b010); exp_at(2, K_OWN, 1);
        exp_at(3, K_GNT, 3'b100); exp_at(3, K_OWN, 2);
        exp_at(4, K_GNT, 3'b001);
        exp_rd(2, 0, 8'h00); exp_rd(3, 1, 8'h00); exp_rd(4, 2, 8'h00); exp_rd(5, 0, 8'h00);
        repeat (4) step();                                // cycle 6

        // Clients 0 and 2 alternate.
        bus.req = 3'b101;
        exp_at(1, K_GNT, 3'b100); exp_at(2, K_GNT, 3'b001); exp_at(3, K_GNT, 3'b100);
        exp_rd(2, 2, 8'h00); exp_rd(3, 0, 8'h00);
        repeat (3) step();                                // cycle 9

        // Nobody requests: idle, then a lone client 1 is granted after one edge.
        bus.req = 3'b000;
        exp_at(1, K_GNT, 0); exp_at(1, K_OWN, 0); exp_at(1, K_RV, 0);
        step();                                           // cycle 10
        bus.req = 3'b010;
        exp_at(1, K_GNT, 3'b010);
        step();                                           // cycle 11

        // Client 1 writes A5 to 0x10, then reads it back.
        bus.addr_in[15:8] = 8'h10; bus.wdata_in[15:8] = 8'hA5; bus.wren_in = 3'b010;
        exp_at(0, K_WREN, 1); exp_at(0, K_MADDR, 8'h10); exp_at(0, K_MWD, 8'hA5);
        exp_at(1, K_RV, 0); exp_at(1, K_GNT, 3'b010);
        step();                                           // cycle 12
        bus.wren_in = 3'b000;
        exp_at(0, K_WREN, 0);
        exp_rd(1, 1, 8'hA5);
        step();                                           // cycle 13

        // Client 1 holds the port for 4 accesses while client 2 waits.
        bus.req = 3'b110; bus.lock = 3'b010;
        exp_at(1, K_GNT, 3'b010); exp_at(2, K_GNT, 3'b010); exp_at(3, K_GNT, 3'b010);
        for (int k = 1; k <= 4; k++) exp_rd(k, 1, 8'hA5);
        repeat (3) step();                                // cycle 16
        bus.lock = 3'b000;
        exp_at(1, K_GNT, 3'b100); exp_at(1, K_OWN, 2);
        step();                                           // cycle 17

        // Client 0 locks, then drops req with lock still high and a write pending.
        bus.req = 3'b101; bus.lock = 3'b001;
        exp_rd(1, 2, 8'h00); exp_at(1, K_GNT, 3'b001);
        step();                                           // cycle 18
        exp_rd(1, 0, 8'h00); exp_at(1, K_GNT, 3'b001);
        step();                                           // cycle 19
        bus.req = 3'b100; bus.wren_in = 3'b001;
        exp_at(0, K_WREN, 0); exp_at(1, K_GNT, 3'b100); exp_at(1, K_RV, 0);
        step();                                           // cycle 20

        // Reset lands on a live write from client 2.
        rst = 1'b1;
        bus.addr_in[23:16] = 8'h20; bus.wdata_in[23:16] = 8'h5A; bus.wren_in = 3'b100;
        exp_at(0, K_WREN, 0); exp_at(1, K_GNT, 0); exp_at(1, K_RV, 0);
        step();                                           // cycle 21
        exp_at(0, K_GNT, 0);
        rst = 1'b0;
        bus.req = 3'b001; bus.lock = 3'b000; bus.wren_in = 3'b000; bus.addr_in[7:0] = 8'h20;
        exp_at(1, K_GNT, 3'b001);
        exp_rd(2, 0, 8'h00);
        step();                                           // cycle 22
        exp_at(1, K_GNT, 3'b001);
        step();                                           // cycle 23

        // Reset during a read: its response must never appear.
        rst = 1'b1;
        exp_at(1, K_RV, 0); exp_at(1, K_GNT, 0);
        step();                                           // cycle 24
        rst = 1'b0;
        bus.req = 3'b010; bus.lock = 3'b010;
        exp_at(1, K_GNT, 3'b010);
        step();                                           // cycle 25

        // Client 1 locked permanently with client 0 contending.
        bus.req = 3'b011;
        for (int k = 1; k <= 4; k++) exp_at(k, K_GNT, 3'b010);
        for (int k = 1; k <= 5; k++) exp_rd(k, 1, 8'hA5);
`ifdef MEM_ARB_WATCHDOG_EN
        exp_at(5, K_GNT, 3'b001); exp_at(5, K_LB, 1); exp_at(6, K_LB, 0);
`else
        exp_at(5, K_GNT, 3'b010); exp_at(5, K_LB, 0); exp_at(6, K_LB, 0);
`endif
        exp_at(6, K_GNT, 0);
        repeat (5) step();                                // cycle 30
        bus.req = 3'b000;
        step();                                           // cycle 31
        step();                                           // cycle 32

        check("pending_expectations", 32'(exp_q.size()), 32'h0);
        check("pending_reads", 32'(rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
